// File: rtl/jcnt_pkg.sv
// Shared package for the Johnson-counter-timed sampler:
// mode encodings and default sizing constants.
package jcnt_pkg;

    localparam int JC_WIDTH  = 4;
    localparam int JC_DATA_W = 8;
    localparam int JC_CH     = 2;
    localparam int JC_CNT_W  = 8;

    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,
        MODE_ZERO = 2'b01,
        MODE_ONES = 2'b10,
        MODE_ALL  = 2'b11
    } mode_e;

endpackage

// File: rtl/jcnt_core.sv
// Enable-gated generalised Johnson counter; with JCNT_SELF_CORRECT_EN
// it flags non-Johnson states and forces them back to zero.
import jcnt_pkg::*;

module jcnt_core #(
    parameter int WIDTH = JC_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
`ifdef JCNT_SELF_CORRECT_EN
    output logic             illegal,
`endif
    output logic [WIDTH-1:0] out
);

`ifdef JCNT_SELF_CORRECT_EN
    logic [WIDTH-2:0] edges;
    logic             seen;
    logic             many;

    assign edges = out[WIDTH-1:1] ^ out[WIDTH-2:0];

    // A legal Johnson word has at most one adjacent-bit transition.
    always_comb begin
        seen = 1'b0;
        many = 1'b0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (edges[i]) begin
                if (seen) many = 1'b1;
                seen = 1'b1;
            end
        end
    end

    assign illegal = many;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out <= '0;
`ifdef JCNT_SELF_CORRECT_EN
        end else if (illegal) begin
            out <= '0;
`endif
        end else if (en) begin
            out <= {out[WIDTH-2:0], ~out[WIDTH-1]};
        end
    end

endmodule

// File: rtl/jcnt_multi_sampler.sv
// Multi-channel sampler captured at selected Johnson phases, with
// valid/ack handshake and sticky overrun. Option: JCNT_SELF_CORRECT_EN.
import jcnt_pkg::*;

module jcnt_multi_sampler #(
    parameter int WIDTH  = JC_WIDTH,
    parameter int DATA_W = JC_DATA_W,
    parameter int CH     = JC_CH,
    parameter int CNT_W  = JC_CNT_W
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [CH*DATA_W-1:0] data_in,
    input  logic                 ack,
    input  logic                 clr_ovr,
    output logic [WIDTH-1:0]     jcnt_out,
    output logic [CH*DATA_W-1:0] data_out,
    output logic                 valid,
    output logic                 overrun,
`ifdef JCNT_SELF_CORRECT_EN
    output logic                 illegal_state,
`endif
    output logic [CNT_W-1:0]     cap_cnt
);

    logic hit;
    logic all_zero;
    logic all_ones;
    logic ovr_set;

    jcnt_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (en),
`ifdef JCNT_SELF_CORRECT_EN
        .illegal (illegal_state),
`endif
        .out     (jcnt_out)
    );

    assign all_zero = (jcnt_out == '0);
    assign all_ones = &jcnt_out;

    always_comb begin
        hit = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_BOTH: hit = all_zero | all_ones;
                MODE_ZERO: hit = all_zero;
                MODE_ONES: hit = all_ones;
                MODE_ALL:  hit = 1'b1;
            endcase
        end
`ifdef JCNT_SELF_CORRECT_EN
        if (illegal_state) hit = 1'b0;
`endif
    end

    // Overwrite of an unacknowledged sample; a same-cycle ack consumes it.
    assign ovr_set = hit & valid & ~ack;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            cap_cnt  <= '0;
        end else begin
            if (hit) begin
                data_out <= data_in;
                valid    <= 1'b1;
                cap_cnt  <= cap_cnt + CNT_W'(1);
            end else if (ack) begin
                valid <= 1'b0;
            end
            overrun <= ovr_set | (overrun & ~clr_ovr);
        end
    end

endmodule

// File: tb/tb_jcnt_multi_sampler.sv
// Directed bench for jcnt_multi_sampler with a reference model
// and a scoreboard of captured samples.
module tb_jcnt_multi_sampler;

    logic        clk;
    logic        n_rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] data_in;
    logic        ack;
    logic        clr_ovr;
    logic [3:0]  jcnt_out;
    logic [15:0] data_out;
    logic        valid;
    logic        overrun;
    logic [7:0]  cap_cnt;
`ifdef JCNT_SELF_CORRECT_EN
    logic        illegal_state;
`endif

    jcnt_multi_sampler #(
        .WIDTH(4), .DATA_W(8), .CH(2), .CNT_W(8)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .en            (en),
        .mode          (mode),
        .data_in       (data_in),
        .ack           (ack),
        .clr_ovr       (clr_ovr),
        .jcnt_out      (jcnt_out),
        .data_out      (data_out),
        .valid         (valid),
        .overrun       (overrun),
`ifdef JCNT_SELF_CORRECT_EN
        .illegal_state (illegal_state),
`endif
        .cap_cnt       (cap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7,
                             4'hF, 4'hE, 4'hC, 4'h8};
    int          m_idx;
    logic        m_valid;
    logic        m_ovr;
    logic [7:0]  m_cnt;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = 8'd0;
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".jcnt"},  32'(jcnt_out), 32'd0);
        chk({tag, ".data"},  32'(data_out), 32'd0);
        chk({tag, ".valid"}, 32'(valid),    32'd0);
        chk({tag, ".ovr"},   32'(overrun),  32'd0);
        chk({tag, ".cnt"},   32'(cap_cnt),  32'd0);
    endtask

    task automatic step(input logic e, input logic [1:0] m,
                        input logic [15:0] d, input logic a,
                        input logic c);
        logic h;
        logic s;
        logic [15:0] exp_d;
        @(negedge clk);
        en = e; mode = m; data_in = d; ack = a; clr_ovr = c;
        case (m)
            2'b00: h = e && (m_idx == 0 || m_idx == 4);
            2'b01: h = e && (m_idx == 0);
            2'b10: h = e && (m_idx == 4);
            default: h = e;
        endcase
        if (h) sb.push_back(d);
        @(posedge clk);
        #1;
        s = h && m_valid && !a;
        if (e) m_idx = (m_idx + 1) % 8;
        if (h) begin
            m_valid = 1'b1;
            m_cnt   = m_cnt + 8'd1;
        end else if (a) begin
            m_valid = 1'b0;
        end
        m_ovr = s | (m_ovr & ~c);
        chk("jcnt",    32'(jcnt_out), 32'(seq[m_idx]));
        chk("valid",   32'(valid),    32'(m_valid));
        chk("overrun", 32'(overrun),  32'(m_ovr));
        chk("cap_cnt", 32'(cap_cnt),  32'(m_cnt));
        if (h) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                exp_d = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(exp_d));
            end
        end
    endtask

    initial begin
        n_rst = 1'b0; en = 1'b0; mode = 2'b00; data_in = 16'h0;
        ack = 1'b0; clr_ovr = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Mode 00, ack held high: captures at 0000 and 1111.
        step(1'b1, 2'b00, 16'hA55A, 1'b1, 1'b0);
        chk("first_data", 32'(data_out), 32'h0000A55A);
        chk("first_cnt",  32'(cap_cnt),  32'd1);
        for (int i = 0; i < 11; i++)
            step(1'b1, 2'b00, 16'hA55A, 1'b1, 1'b0);
        chk("both_cnt", 32'(cap_cnt), 32'd3);

        // Mode 01 with 3-cycle en gaps.
        for (int i = 0; i < 20; i++)
            step((i % 7) < 4, 2'b01, 16'(i * 37 + 5), 1'b1, 1'b0);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        #2;
        n_rst = 1'b1;

        // Overrun: newest wins, sticky, clear, set beats clear.
        step(1'b1, 2'b11, 16'h0102, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'h0304, 1'b0, 1'b0);
        chk("ovr_data", 32'(data_out), 32'h00000304);
        chk("ovr_set",  32'(overrun),  32'd1);
        step(1'b0, 2'b11, 16'h0000, 1'b0, 1'b0);
        chk("ovr_hold", 32'(overrun),  32'd1);
        step(1'b0, 2'b11, 16'h0000, 1'b0, 1'b1);
        chk("ovr_clr",  32'(overrun),  32'd0);
        step(1'b1, 2'b11, 16'h0506, 1'b0, 1'b1);
        chk("ovr_setwins", 32'(overrun), 32'd1);
        step(1'b0, 2'b11, 16'h0000, 1'b0, 1'b1);

        // Hit and ack together.
        step(1'b1, 2'b11, 16'h0708, 1'b1, 1'b0);
        chk("hitack_valid", 32'(valid),    32'd1);
        chk("hitack_ovr",   32'(overrun),  32'd0);
        chk("hitack_data",  32'(data_out), 32'h00000708);

        // Ack with no hit drops valid, data held.
        step(1'b0, 2'b11, 16'hFFFF, 1'b1, 1'b0);
        chk("ack_drop", 32'(valid),    32'd0);
        chk("ack_hold", 32'(data_out), 32'h00000708);

        // 4 captures so far; 252 more wraps the counter.
        for (int i = 0; i < 252; i++)
            step(1'b1, 2'b11, 16'(i), 1'b1, 1'b0);
        chk("wrap", 32'(cap_cnt), 32'd0);

`ifdef JCNT_SELF_CORRECT_EN
        @(negedge clk);
        en = 1'b1; mode = 2'b11; ack = 1'b1; clr_ovr = 1'b0;
        force dut.u_core.out = 4'b0101;
        #1;
        release dut.u_core.out;
        #1;
        chk("illegal_on", 32'(illegal_state), 32'd1);
        @(posedge clk);
        #1;
        chk("sc_jcnt",     32'(jcnt_out),      32'd0);
        chk("illegal_off", 32'(illegal_state), 32'd0);
        chk("sc_nocap",    32'(cap_cnt),       32'd0);
        m_idx = 0;
        m_valid = 1'b0;
        step(1'b1, 2'b11, 16'h1234, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jcnt_multi_sampler.md
Name: jcnt_multi_sampler

Overview:
- Parametrised Johnson-counter-timed sampler for multi-channel data.
- A free-running, enable-gated Johnson counter sets the sample instants. The channel bus is captured into a register at the selected counter phases.
- Captured data is presented with a valid/ack handshake, an overrun flag and a capture count.
- Successor to the single-channel all-zeros/all-ones latch sampler. Capture is now edge-registered, not level-latched.

Parameters:
- WIDTH, 4: Johnson counter width; count period = 2*WIDTH cycles; minimum 2.
- DATA_W, 8: bits per channel.
- CH, 2: number of channels; data bus width = CH*DATA_W.
- CNT_W, 8: width of the capture counter.

Ports:
- clk  in  1  rising-edge clock.
- n_rst  in  1  asynchronous active-low reset.
- en  in  1  counter advance and capture enable.
- mode  in  2  capture-phase select (see Behaviour).
- data_in  in  CH*DATA_W  channel bus; channel k occupies bits [k*DATA_W +: DATA_W].
- ack  in  1  consumer acknowledges the current sample.
- clr_ovr  in  1  clears the sticky overrun flag.
- jcnt_out  out  WIDTH  current Johnson counter value.
- data_out  out  CH*DATA_W  last captured sample.
- valid  out  1  an unacknowledged sample is held.
- overrun  out  1  sticky flag: a sample was overwritten before ack.
- cap_cnt  out  CNT_W  number of captures, wrapping.

Behaviour:
- Reset:
  - Async assert on n_rst=0. jcnt_out, data_out, valid, overrun and cap_cnt are all 0.
  - Reset mid-operation aborts the pending sample immediately. No output holds its pre-reset value.
- Counter:
  - When en=1: jcnt <= {jcnt[WIDTH-2:0], ~jcnt[WIDTH-1]}.
  - WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
  - When en=0: counter holds.
- Hit, combinational on the current jcnt, only when en=1:
  - mode 00: jcnt all-zeros or all-ones (2 hits per period, WIDTH cycles apart).
  - mode 01: all-zeros only.
  - mode 10: all-ones only.
  - mode 11: every cycle.
  - A mode change applies to the next evaluated cycle.
- Capture on hit, at the same rising edge:
  - data_out <= data_in, valid <= 1, cap_cnt <= cap_cnt+1 (wraps from 2^CNT_W-1 to 0).
  - Latency: data_in sampled at edge N appears on data_out after edge N. No combinational path from data_in to data_out.
- Handshake:
  - ack is meaningful only while valid=1; ack with valid=0 is ignored.
  - ack=1 and no hit: valid <= 0; data_out holds.
  - Hit and ack=1 in the same cycle: new data is taken, valid stays 1, overrun is unchanged.
  - Hit while valid=1 and ack=0: newest data wins (overwrite), overrun <= 1.
- Overrun:
  - Sticky until clr_ovr=1.
  - If clr_ovr and a new overrun event occur in the same cycle, set wins.
- en=0 with valid=1: the sample is held, and ack still clears valid.
- Arithmetic: cap_cnt is unsigned modulo 2^CNT_W. No other arithmetic.

Optional Feature:
- Macro: JCNT_SELF_CORRECT_EN.
- Defined:
  - Legal Johnson states are exactly those of the form 0..01..1 or 1..10..0.
  - Any other jcnt value (e.g. an upset) is detected combinationally. The next edge forces jcnt to 0 regardless of en, and no hit occurs in that cycle.
  - Additional output illegal_state, 1 bit, pulses for that cycle.
- Not defined:
  - No detection is performed; an illegal state circulates in its own orbit.
  - The illegal_state port is absent.

Decomposition:
- Shared package jcnt_pkg:
  - mode encodings MODE_BOTH=2'b00, MODE_ZERO=2'b01, MODE_ONES=2'b10, MODE_ALL=2'b11.
  - Default WIDTH, DATA_W, CH and CNT_W constants.
- Sub-module jcnt_core (parameter WIDTH; ports clk, n_rst, en, out):
  - The generalised Johnson counter.
  - Also hosts the self-correction logic when JCNT_SELF_CORRECT_EN is defined.
- The top level holds the hit decode, capture register, handshake and counters.

Test Plan (WIDTH=4, DATA_W=8, CH=2, CNT_W=8):
- Reset mid-run: n_rst=0 between edges -> all outputs 0 immediately, with no clock edge needed.
- Capture and handshake: en=1, mode=00, data_in=16'hA55A, ack=1 -> captures on jcnt=0000 and 1111, exactly 4 cycles apart; data_out=A55A after the edge; cap_cnt +1 per capture; valid drops the cycle after ack.
- Mode 01 with en gaps: en deasserted for 3 cycles -> counter frozen, captures only at 0000, total period 8 enabled cycles.
- Overrun: mode=11, ack=0, data_in=0x0102 then 0x0304 -> data_out=0304 (newest wins), overrun=1 and held. Apply clr_ovr with no new hit -> overrun=0. Apply clr_ovr with a simultaneous overrun event -> overrun stays 1.
- Simultaneous hit and ack: valid=1, ack=1 on a hit cycle -> valid stays 1, new data taken, overrun stays 0.
- Wrap and self-correct: 256 captures -> cap_cnt wraps to 0. With JCNT_SELF_CORRECT_EN defined, force jcnt=0101 -> next edge jcnt=0000, illegal_state pulses for one cycle, no capture.
